// File: rtl/trisc_pkg.sv
// Shared types and sizes for the TRISC program loader.
// Optional checksum stage is built with TRISC_LOADER_CHECKSUM_EN.
package trisc_pkg;

  localparam int TRISC_ADDR_W = 4;
  localparam int TRISC_DATA_W = 8;
  localparam int TRISC_DEPTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    ERROR,
    DONE
  } loader_state_t;

endpackage

// File: rtl/trisc_program_loader_if.sv
// Byte-stream valid/ready handshake feeding the program loader.
// master = byte source, slave = loader.
interface trisc_program_loader_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] inData;
  logic              inValid;
  logic              inReady;

  modport master (
    output inData,
    output inValid,
    input  inReady
  );

  modport slave (
    input  inData,
    input  inValid,
    output inReady
  );

endinterface

// File: rtl/trisc_loader_counter.sv
// RAM address counter: sync clear, increment, terminal flag.
// tc is high when the count sits on the last program word.
module trisc_loader_counter #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  // Address register; clear wins over increment.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/trisc_program_loader.sv
// Streams DEPTH bytes into the TRISC program RAM, holding the CPU.
// Define TRISC_LOADER_CHECKSUM_EN for a trailing checksum byte.
module trisc_program_loader
  import trisc_pkg::*;
#(
  parameter int ADDR_W = TRISC_ADDR_W,
  parameter int DATA_W = TRISC_DATA_W,
  parameter int DEPTH  = TRISC_DEPTH
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   start,
  trisc_program_loader_if.slave  in_if,
  output logic [ADDR_W-1:0]      ramAddress,
  output logic [DATA_W-1:0]      ramData,
  output logic                   ramWrite,
  output logic                   cpuHold,
  output logic                   loadDone,
  output logic                   loadErr
);

  loader_state_t     state;
  logic              ready_q;
  logic [ADDR_W-1:0] count;
  logic              tc;
  logic              clr;
  logic              inc;
  logic              xfer;
  logic              restart;

  assign in_if.inReady = ready_q;
  assign xfer = in_if.inValid && ready_q;

`ifdef TRISC_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] total;
  logic              err_q;

  assign restart = start && (state == IDLE ||
                             state == DONE ||
                             state == ERROR);
  assign total   = sum + in_if.inData;
  assign loadErr = err_q;

  // Running modulo-2^DATA_W sum of the bytes written to RAM.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sum <= '0;
    end else if (restart) begin
      sum <= '0;
    end else if (state == LOAD && xfer) begin
      sum <= total;
    end
  end
`else
  assign restart = start && (state == IDLE ||
                             state == DONE);
  assign loadErr = 1'b0;
`endif

  assign clr = restart;
  assign inc = (state == WRITE) && !tc;

  trisc_loader_counter #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_counter (
    .clock  (clock),
    .resetN (resetN),
    .clr    (clr),
    .inc    (inc),
    .count  (count),
    .tc     (tc)
  );

  // Load sequencer with registered handshake and RAM outputs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      ramWrite   <= 1'b0;
      ramAddress <= '0;
      ramData    <= '0;
      cpuHold    <= 1'b1;
      loadDone   <= 1'b0;
`ifdef TRISC_LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
`endif
    end else begin
      ramWrite <= 1'b0;
      if (restart) begin
        state    <= LOAD;
        ready_q  <= 1'b1;
        cpuHold  <= 1'b1;
        loadDone <= 1'b0;
`ifdef TRISC_LOADER_CHECKSUM_EN
        err_q    <= 1'b0;
`endif
      end else begin
        unique case (state)
          LOAD: begin
            if (xfer) begin
              state      <= WRITE;
              ready_q    <= 1'b0;
              ramWrite   <= 1'b1;
              ramAddress <= count;
              ramData    <= in_if.inData;
            end
          end
          WRITE: begin
            if (tc) begin
`ifdef TRISC_LOADER_CHECKSUM_EN
              state    <= CHECK;
              ready_q  <= 1'b1;
`else
              state    <= DONE;
              loadDone <= 1'b1;
              cpuHold  <= 1'b0;
`endif
            end else begin
              state   <= LOAD;
              ready_q <= 1'b1;
            end
          end
`ifdef TRISC_LOADER_CHECKSUM_EN
          CHECK: begin
            if (xfer) begin
              ready_q <= 1'b0;
              if (total == '0) begin
                state    <= DONE;
                loadDone <= 1'b1;
                cpuHold  <= 1'b0;
              end else begin
                state <= ERROR;
                err_q <= 1'b1;
              end
            end
          end
          ERROR: state <= ERROR;
`endif
          IDLE:    state <= IDLE;
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
